// File: rtl/mips_pkg.sv
// Shared types and defaults for the instruction fetch path.
// The branch-delay-slot build option is selected with the IFU_DELAY_SLOT_EN macro.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_WORD_DEF     = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } ifu_state_t;

    function automatic logic word_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Next-pc selection for the fetch unit: reset vector, redirect target, sequential pc+4, or hold.
module ifu_pc_gen
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic              advance,
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] redirect_target,
    output logic [WORD_W-1:0] pc_next
);

    // Priority order: reset, redirect, sequential advance, hold. The +4 wraps naturally.
    always_comb begin
        pc_next = pc;
        if (reset) begin
            pc_next = RESET_VECTOR;
        end else if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: reads the ROM at pc and hands {pc, inst, fault} tokens to decode via valid/ready.
// Define IFU_DELAY_SLOT_EN to keep the word after a redirect as a MIPS branch delay slot.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [WORD_W-1:0] NOP_WORD     = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    input  logic              rom_accessable,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [WORD_W-1:0] if_inst,
    output logic [WORD_W-1:0] if_pc,
    output logic              if_fault
);

    ifu_state_t        state_reg;
    logic [WORD_W-1:0] pc_reg;
    logic [WORD_W-1:0] pc_next;
    logic              if_valid_reg;
    logic [WORD_W-1:0] if_inst_reg;
    logic [WORD_W-1:0] if_pc_reg;
    logic              if_fault_reg;

    logic free;
    logic ok;
    logic capture;
    logic advance;

    assign free = !if_valid_reg || if_ready;
    assign ok   = rom_accessable && word_aligned(pc_reg);

`ifdef IFU_DELAY_SLOT_EN
    // The word at pc is the delay slot, so a redirect does not stop the capture.
    assign capture = (state_reg == RUN) && free;
`else
    assign capture = (state_reg == RUN) && free && !redirect_valid;
`endif

    assign advance = capture && ok;

    ifu_pc_gen #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc_gen (
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .advance        (advance),
        .pc             (pc_reg),
        .redirect_target(redirect_target),
        .pc_next        (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= RESET_VECTOR;
            state_reg    <= RUN;
            if_valid_reg <= 1'b0;
            if_inst_reg  <= '0;
            if_pc_reg    <= '0;
            if_fault_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            if (capture) begin
                if_valid_reg <= 1'b1;
                if_pc_reg    <= pc_reg;
                if_inst_reg  <= ok ? rom_data : NOP_WORD;
                if_fault_reg <= !ok;
                if (!ok) begin
                    state_reg <= FAULT;
                end
            end else if (state_reg == FAULT) begin
                // A redirect discards the fault token even if decode never took it.
                if (redirect_valid) begin
                    if_valid_reg <= 1'b0;
                    state_reg    <= RUN;
                end else if (if_ready) begin
                    if_valid_reg <= 1'b0;
                end
            end
`ifndef IFU_DELAY_SLOT_EN
            else if (redirect_valid) begin
                if_valid_reg <= 1'b0;
            end
`endif
        end
    end

    assign rom_addr = pc_reg;
    assign if_valid = if_valid_reg;
    assign if_inst  = if_inst_reg;
    assign if_pc    = if_pc_reg;
    assign if_fault = if_fault_reg;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by random traffic against a token-level model.
module tb_inst_fetch_unit;
    import mips_pkg::*;

`ifdef IFU_DELAY_SLOT_EN
    localparam bit DELAY = 1'b1;
`else
    localparam bit DELAY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_accessable;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_fault;
    logic        force_inacc;

    int errors = 0;
    int checks = 0;

    // Reference model: fetch pointer, the pending token, and whether fetch is stopped on a fault.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_tpc;
    logic [31:0] m_inst;
    logic        m_fault;
    logic        m_stopped;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_accessable (rom_accessable),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h3c11_4000;
            32'h0000_0004: return 32'h2631_0000;
            32'h0000_0008: return 32'h0220_0008;
            default:       return a ^ 32'hA5A5_0000 ^ (a << 7);
        endcase
    endfunction

    function automatic logic mapped(input logic [31:0] a);
        return (a < 32'h0000_0100) ||
               (a >= 32'h0040_0000 && a < 32'h0040_0100) ||
               (a >= 32'hFFFF_FFF0);
    endfunction

    always_comb begin
        rom_data       = rom_word(rom_addr);
        rom_accessable = mapped(rom_addr) && !force_inacc;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic rd, input logic [31:0] tgt,
                                input logic rdy, input logic inacc);
        logic ok;
        logic free;
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_tpc = 32'h0; m_inst = 32'h0;
            m_fault = 1'b0; m_stopped = 1'b0;
            return;
        end
        ok   = mapped(m_pc) && !inacc && (m_pc % 4 == 0);
        free = !m_valid || rdy;
        if (m_valid && rdy)
            $display("token pc=%h inst=%h fault=%0b", m_tpc, m_inst, m_fault);
        if (m_stopped) begin
            if (rd) begin
                m_pc = tgt; m_valid = 1'b0; m_stopped = 1'b0;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end else if (!DELAY && rd) begin
            m_valid = 1'b0;
            m_pc    = tgt;
        end else begin
            if (free) begin
                m_valid = 1'b1;
                m_tpc   = m_pc;
                m_inst  = ok ? rom_word(m_pc) : 32'h0;
                m_fault = !ok;
                if (ok) m_pc = m_pc + 32'd4;
                else    m_stopped = 1'b1;
            end
            if (rd) m_pc = tgt;
        end
    endtask

    task automatic compare();
        chk("rom_addr", rom_addr, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("if_pc", if_pc, m_tpc);
            chk("if_inst", if_inst, m_inst);
            chk("if_fault", {31'b0, if_fault}, {31'b0, m_fault});
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), clock it, then check at the next falling edge.
    task automatic step(input logic rst, input logic rd, input logic [31:0] tgt,
                        input logic rdy, input logic inacc);
        reset = rst; redirect_valid = rd; redirect_target = tgt;
        if_ready = rdy; force_inacc = inacc;
        model_update(rst, rd, tgt, rdy, inacc);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [31:0] tgt;
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        if_ready = 1'b0; force_inacc = 1'b0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_fault", {31'b0, if_fault}, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_addr", rom_addr, 32'h0);

        // Boot stub streams with one-cycle latency
        step(0, 0, 0, 1, 0);
        chk("boot_pc0", if_pc, 32'h0);
        chk("boot_inst0", if_inst, 32'h3c11_4000);
        step(0, 0, 0, 1, 0);
        chk("boot_pc4", if_pc, 32'h4);
        chk("boot_inst4", if_inst, 32'h2631_0000);
        step(0, 0, 0, 1, 0);
        chk("boot_pc8", if_pc, 32'h8);
        chk("boot_inst8", if_inst, 32'h0220_0008);

        // Redirect: non-delay flushes, delay mode delivers the slot word at 0xC
        step(0, 1, 32'h0040_0000, 1, 0);
`ifdef IFU_DELAY_SLOT_EN
        chk("redir_slot_pc", if_pc, 32'hC);
`else
        chk("redir_flush", {31'b0, if_valid}, 32'h0);
`endif
        step(0, 0, 0, 1, 0);
        chk("redir_pc", if_pc, 32'h0040_0000);
        chk("redir_valid", {31'b0, if_valid}, 32'h1);

        // Backpressure holds the token and the fetch address
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("stall_pc", if_pc, 32'h0);
            chk("stall_inst", if_inst, 32'h3c11_4000);
            chk("stall_addr", rom_addr, 32'h4);
        end
        step(0, 0, 0, 1, 0);
        chk("release_pc", if_pc, 32'h4);

        // Fetch fault at 0xC, held until accepted, then silent until redirect
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("fault_flag", {31'b0, if_fault}, 32'h1);
        chk("fault_inst", if_inst, 32'h0);
        chk("fault_pc", if_pc, 32'hC);
        step(0, 0, 0, 0, 0);
        chk("fault_held", {31'b0, if_valid}, 32'h1);
        step(0, 0, 0, 1, 0);
        chk("fault_taken", {31'b0, if_valid}, 32'h0);
        step(0, 0, 0, 1, 0);
        chk("fault_idle", {31'b0, if_valid}, 32'h0);
        chk("fault_addr", rom_addr, 32'hC);
        step(0, 1, 32'h0040_0000, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("resume_pc", if_pc, 32'h0040_0000);
        chk("resume_fault", {31'b0, if_fault}, 32'h0);

        // Misaligned redirect target produces a fault token
        step(0, 1, 32'h0040_0002, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("misal_pc", if_pc, 32'h0040_0002);
        chk("misal_fault", {31'b0, if_fault}, 32'h1);
        step(0, 0, 0, 1, 0);
        chk("misal_stop", rom_addr, 32'h0040_0002);

`ifdef IFU_DELAY_SLOT_EN
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h0040_0000, 1, 0);
        chk("ds_slot_pc", if_pc, 32'h8);
        step(0, 0, 0, 1, 0);
        chk("ds_target_pc", if_pc, 32'h0040_0000);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("ds_rst_valid", {31'b0, if_valid}, 32'h0);
        chk("ds_rst_addr", rom_addr, 32'h0);
`endif

        // Random traffic, including wrap-around from 0xFFFFFFFC
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: tgt = 32'h0040_0000 + 32'($urandom_range(0, 60)) * 4;
                1: tgt = 32'($urandom_range(0, 60)) * 4;
                2: tgt = 32'h0040_0002;
                default: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            endcase
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 7) == 0),
                 tgt,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
